// File: rtl/mix_layer_mvm_core.sv
// Dense matrix-vector product q = W_L * d for one mix layer, streaming one
// DATA_N-wide weight word per cycle from a ROM with one cycle of read latency.
module mix_layer_mvm_core #(
  parameter int N_LEN   = 16,
  parameter int F_LEN   = 8,
  parameter int DATA_N  = 8,
  parameter int HID_DIM = 24,
  parameter int ADDR_W  = N_LEN
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      run,
  input  logic [1:0]                layer_sel,
  input  logic [HID_DIM*N_LEN-1:0]  d,
  output logic [ADDR_W-1:0]         addr,
  input  logic [DATA_N*N_LEN-1:0]   weight,
  output logic [HID_DIM*N_LEN-1:0]  q,
  output logic                      valid,
  output logic                      busy
);

  localparam int C      = HID_DIM / DATA_N;
  localparam int WN     = HID_DIM * C;
  localparam int PROD_W = 2 * N_LEN;
  localparam int ACC_W  = 2 * N_LEN + $clog2(HID_DIM);
  localparam int KW     = (C > 1) ? $clog2(C) : 1;
  localparam int JW     = $clog2(HID_DIM);
  localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'((2 ** (N_LEN - 1)) - 1);
  localparam logic signed [ACC_W-1:0] MIN_V = ~MAX_V;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t                    state_reg;
  logic [ADDR_W-1:0]         addr_reg;
  logic [ADDR_W-1:0]         last_addr_reg;
  logic                      busy_reg;
  logic                      valid_reg;
  logic                      fetch_reg;
  logic                      rd_valid_reg;
  logic signed [ACC_W-1:0]   acc_reg;
  logic [KW-1:0]             k_reg;
  logic [JW-1:0]             j_reg;
  logic signed [N_LEN-1:0]   d_reg [HID_DIM];
  logic signed [N_LEN-1:0]   q_reg [HID_DIM];

  logic signed [N_LEN-1:0]   w_elem [DATA_N];
  logic signed [PROD_W-1:0]  prod [DATA_N];
  logic signed [ACC_W-1:0]   partial;
  logic signed [ACC_W-1:0]   row_sum;
  logic signed [ACC_W-1:0]   shifted;
  logic signed [N_LEN-1:0]   sat_val;
  logic [ADDR_W-1:0]         base_addr;

  genvar gi;
  generate
    for (gi = 0; gi < DATA_N; gi++) begin : g_lane
      assign w_elem[gi] = weight[gi*N_LEN +: N_LEN];
      assign prod[gi]   = PROD_W'(w_elem[gi]) * PROD_W'(d_reg[JW'(int'(k_reg) * DATA_N + gi)]);
    end
    for (gi = 0; gi < HID_DIM; gi++) begin : g_out
      assign q[gi*N_LEN +: N_LEN] = q_reg[gi];
    end
  endgenerate

  always_comb begin
    partial = '0;
    for (int i = 0; i < DATA_N; i++) begin
      partial = partial + ACC_W'(prod[i]);
    end
    row_sum = acc_reg + partial;
    // Arithmetic shift floors toward minus infinity before saturation.
    shifted = row_sum >>> F_LEN;
    if (shifted > MAX_V)
      sat_val = MAX_V[N_LEN-1:0];
    else if (shifted < MIN_V)
      sat_val = MIN_V[N_LEN-1:0];
    else
      sat_val = shifted[N_LEN-1:0];
    base_addr = ADDR_W'(layer_sel) * ADDR_W'(WN);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      last_addr_reg <= '0;
      busy_reg      <= 1'b0;
      valid_reg     <= 1'b0;
      fetch_reg     <= 1'b0;
      rd_valid_reg  <= 1'b0;
      acc_reg       <= '0;
      k_reg         <= '0;
      j_reg         <= '0;
      for (int i = 0; i < HID_DIM; i++) begin
        d_reg[i] <= '0;
        q_reg[i] <= '0;
      end
    end else begin
      valid_reg    <= 1'b0;
      rd_valid_reg <= fetch_reg;
      case (state_reg)
        IDLE: begin
          if (run && layer_sel != 2'd3) begin
            for (int i = 0; i < HID_DIM; i++) d_reg[i] <= d[i*N_LEN +: N_LEN];
            addr_reg      <= base_addr;
            last_addr_reg <= base_addr + ADDR_W'(WN - 1);
            busy_reg      <= 1'b1;
            fetch_reg     <= 1'b1;
            acc_reg       <= '0;
            k_reg         <= '0;
            j_reg         <= '0;
            state_reg     <= FETCH;
          end
        end
        FETCH: begin
          addr_reg <= addr_reg + ADDR_W'(1);
          if (addr_reg + ADDR_W'(1) == last_addr_reg) state_reg <= DRAIN;
        end
        DRAIN: begin
          fetch_reg <= 1'b0;
          // Leave only after the valid cycle so busy covers it.
          if (valid_reg) begin
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase

      if (rd_valid_reg) begin
        if (k_reg == KW'(C - 1)) begin
          q_reg[j_reg] <= sat_val;
          acc_reg      <= '0;
          k_reg        <= '0;
          if (j_reg == JW'(HID_DIM - 1)) begin
            j_reg     <= '0;
            valid_reg <= 1'b1;
          end else begin
            j_reg <= j_reg + JW'(1);
          end
        end else begin
          acc_reg <= row_sum;
          k_reg   <= k_reg + KW'(1);
        end
      end
    end
  end

  assign addr  = addr_reg;
  assign valid = valid_reg;
  assign busy  = busy_reg;

endmodule
